// File: rtl/ctrl_rx.sv
// rtl/ctrl_rx.sv - UART command decoder driving register-file and ALU requests
// Decodes AA/BB/CC/DD command frames and forwards RF/ALU responses to the TX controller.
module ctrl_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int RF_ADDR    = 4,
    parameter int WAIT_MAX   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   rx_p_data,
    input  logic                    rx_d_vld,
    output logic                    rf_wr_en,
    output logic                    rf_rd_en,
    output logic [RF_ADDR-1:0]      rf_addr,
    output logic [DATA_WIDTH-1:0]   rf_wr_data,
    input  logic                    rf_rd_data_vld,
    input  logic [DATA_WIDTH-1:0]   rf_rd_data,
    output logic                    alu_en,
    output logic [3:0]              alu_fun,
    input  logic                    alu_out_vld,
    input  logic [2*DATA_WIDTH-1:0] alu_out,
    output logic                    clk_gate_en,
    output logic                    tx_rf_send,
    output logic                    tx_alu_send,
    output logic [DATA_WIDTH-1:0]   tx_rf_send_data,
    output logic [2*DATA_WIDTH-1:0] tx_alu_send_data
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] WR_ADDR  = 4'd1;
    localparam logic [3:0] WR_DATA  = 4'd2;
    localparam logic [3:0] RD_ADDR  = 4'd3;
    localparam logic [3:0] RD_WAIT  = 4'd4;
    localparam logic [3:0] OPA      = 4'd5;
    localparam logic [3:0] OPB      = 4'd6;
    localparam logic [3:0] ALU_FUN  = 4'd7;
    localparam logic [3:0] ALU_WAIT = 4'd8;

    localparam int CW = $clog2(WAIT_MAX + 1);

    localparam logic [DATA_WIDTH-1:0] OP_WR      = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RD      = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OP_ALU     = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_NOP = DATA_WIDTH'(8'hDD);

    logic [3:0]         state;
    logic [CW-1:0]      wait_cnt;
    logic [RF_ADDR-1:0] addr_q;
    logic               timeout;

    // Last permitted wait cycle; a response arriving here still wins.
    assign timeout     = (wait_cnt == CW'(WAIT_MAX - 1));
    assign alu_en      = (state == ALU_WAIT);
    assign clk_gate_en = (state == OPA) || (state == OPB) ||
                         (state == ALU_FUN) || (state == ALU_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            addr_q           <= '0;
            rf_wr_en         <= 1'b0;
            rf_rd_en         <= 1'b0;
            rf_addr          <= '0;
            rf_wr_data       <= '0;
            alu_fun          <= '0;
            tx_rf_send       <= 1'b0;
            tx_alu_send      <= 1'b0;
            tx_rf_send_data  <= '0;
            tx_alu_send_data <= '0;
        end else begin
            rf_wr_en    <= 1'b0;
            rf_rd_en    <= 1'b0;
            tx_rf_send  <= 1'b0;
            tx_alu_send <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_d_vld) begin
                        if (rx_p_data == OP_WR)           state <= WR_ADDR;
                        else if (rx_p_data == OP_RD)      state <= RD_ADDR;
                        else if (rx_p_data == OP_ALU)     state <= OPA;
                        else if (rx_p_data == OP_ALU_NOP) state <= ALU_FUN;
                    end
                end
                WR_ADDR: begin
                    if (rx_d_vld) begin
                        addr_q <= rx_p_data[RF_ADDR-1:0];
                        state  <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (rx_d_vld) begin
                        rf_wr_en   <= 1'b1;
                        rf_addr    <= addr_q;
                        rf_wr_data <= rx_p_data;
                        state      <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (rx_d_vld) begin
                        rf_rd_en <= 1'b1;
                        rf_addr  <= rx_p_data[RF_ADDR-1:0];
                        wait_cnt <= '0;
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rf_rd_data_vld) begin
                        tx_rf_send      <= 1'b1;
                        tx_rf_send_data <= rf_rd_data;
                        wait_cnt        <= '0;
                        state           <= IDLE;
                    end else if (timeout) begin
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                OPA: begin
                    if (rx_d_vld) begin
                        rf_wr_en   <= 1'b1;
                        rf_addr    <= RF_ADDR'(0);
                        rf_wr_data <= rx_p_data;
                        state      <= OPB;
                    end
                end
                OPB: begin
                    if (rx_d_vld) begin
                        rf_wr_en   <= 1'b1;
                        rf_addr    <= RF_ADDR'(1);
                        rf_wr_data <= rx_p_data;
                        state      <= ALU_FUN;
                    end
                end
                ALU_FUN: begin
                    if (rx_d_vld) begin
                        alu_fun  <= rx_p_data[3:0];
                        wait_cnt <= '0;
                        state    <= ALU_WAIT;
                    end
                end
                ALU_WAIT: begin
                    if (alu_out_vld) begin
                        tx_alu_send      <= 1'b1;
                        tx_alu_send_data <= alu_out;
                        wait_cnt         <= '0;
                        state            <= IDLE;
                    end else if (timeout) begin
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: begin
                    wait_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_rx.sv
// tb/tb_ctrl_rx.sv - randomized and directed check of ctrl_rx against a frame-level model
module tb_ctrl_rx;

    localparam int WAIT_MAX = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_p_data;
    logic        rx_d_vld;
    logic        rf_wr_en, rf_rd_en;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wr_data;
    logic        rf_rd_data_vld;
    logic [7:0]  rf_rd_data;
    logic        alu_en;
    logic [3:0]  alu_fun;
    logic        alu_out_vld;
    logic [15:0] alu_out;
    logic        clk_gate_en;
    logic        tx_rf_send, tx_alu_send;
    logic [7:0]  tx_rf_send_data;
    logic [15:0] tx_alu_send_data;

    ctrl_rx #(.DATA_WIDTH(8), .RF_ADDR(4), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset),
        .rx_p_data(rx_p_data), .rx_d_vld(rx_d_vld),
        .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr),
        .rf_wr_data(rf_wr_data), .rf_rd_data_vld(rf_rd_data_vld), .rf_rd_data(rf_rd_data),
        .alu_en(alu_en), .alu_fun(alu_fun), .alu_out_vld(alu_out_vld), .alu_out(alu_out),
        .clk_gate_en(clk_gate_en), .tx_rf_send(tx_rf_send), .tx_alu_send(tx_alu_send),
        .tx_rf_send_data(tx_rf_send_data), .tx_alu_send_data(tx_alu_send_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Frame-level model: current opcode, operand bytes seen, and response wait age.
    int          m_op, m_nb, m_age;
    bit          m_wait;
    logic [3:0]  m_pend_addr;
    logic        e_wr, e_rd, e_txr, e_txa;
    logic [3:0]  e_addr, e_fun;
    logic [7:0]  e_wdata, e_txr_data;
    logic [15:0] e_txa_data;

    task automatic model_clear();
        m_op = 0; m_nb = 0; m_age = 0; m_wait = 0; m_pend_addr = 0;
        e_wr = 0; e_rd = 0; e_txr = 0; e_txa = 0;
        e_addr = 0; e_fun = 0; e_wdata = 0; e_txr_data = 0; e_txa_data = 0;
    endtask

    task automatic m_write(input logic [3:0] a, input logic [7:0] d);
        e_wr = 1; e_addr = a; e_wdata = d;
    endtask

    task automatic model_step();
        bit resp;
        e_wr = 0; e_rd = 0; e_txr = 0; e_txa = 0;
        if (m_wait) begin
            m_age++;
            resp = (m_op == 'hBB) ? rf_rd_data_vld : alu_out_vld;
            if (resp) begin
                if (m_op == 'hBB) begin e_txr = 1; e_txr_data = rf_rd_data; end
                else              begin e_txa = 1; e_txa_data = alu_out;    end
                m_wait = 0; m_op = 0;
            end else if (m_age == WAIT_MAX) begin
                m_wait = 0; m_op = 0;
            end
        end else if (rx_d_vld) begin
            if (m_op == 0) begin
                if (rx_p_data inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) begin
                    m_op = rx_p_data; m_nb = 0;
                end
            end else begin
                m_nb++;
                case (m_op)
                    'hAA: if (m_nb == 1) m_pend_addr = rx_p_data[3:0];
                          else begin m_write(m_pend_addr, rx_p_data); m_op = 0; end
                    'hBB: begin e_rd = 1; e_addr = rx_p_data[3:0]; m_wait = 1; m_age = 0; end
                    'hCC: if (m_nb == 1)      m_write(4'd0, rx_p_data);
                          else if (m_nb == 2) m_write(4'd1, rx_p_data);
                          else begin e_fun = rx_p_data[3:0]; m_wait = 1; m_age = 0; end
                    default: begin e_fun = rx_p_data[3:0]; m_wait = 1; m_age = 0; end
                endcase
            end
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            if (reset) model_clear();
            else       model_step();
        end
    end

    bit cmp_en = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            if (reset) begin
                chk("rst_outputs", {rf_wr_en, rf_rd_en, tx_rf_send, tx_alu_send, alu_en,
                                    clk_gate_en, rf_addr, alu_fun}, 32'd0);
                chk("rst_payloads", {rf_wr_data, tx_rf_send_data, tx_alu_send_data}, 32'd0);
            end else begin
                chk("rf_wr_en", rf_wr_en, e_wr);
                chk("rf_rd_en", rf_rd_en, e_rd);
                chk("tx_rf_send", tx_rf_send, e_txr);
                chk("tx_alu_send", tx_alu_send, e_txa);
                chk("alu_en", alu_en, m_wait && (m_op == 'hCC || m_op == 'hDD));
                chk("clk_gate_en", clk_gate_en, (m_op == 'hCC || m_op == 'hDD));
                chk("rf_addr", rf_addr, e_addr);
                chk("rf_wr_data", rf_wr_data, e_wdata);
                chk("alu_fun", alu_fun, e_fun);
                chk("tx_rf_send_data", tx_rf_send_data, e_txr_data);
                chk("tx_alu_send_data", tx_alu_send_data, e_txa_data);
                chk("strobe_onehot", (32'(rf_wr_en) + 32'(rf_rd_en) + 32'(tx_rf_send)
                                      + 32'(tx_alu_send)) <= 1, 1);
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 of the edge that consumed the byte.
    task automatic send_byte(input logic [7:0] b);
        rx_d_vld = 1; rx_p_data = b;
        @(posedge clk); #2;
        rx_d_vld = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    logic [7:0] opc [4];

    initial begin
        opc[0] = 8'hAA; opc[1] = 8'hBB; opc[2] = 8'hCC; opc[3] = 8'hDD;
        reset = 1; rx_d_vld = 0; rx_p_data = 0;
        rf_rd_data_vld = 0; rf_rd_data = 0; alu_out_vld = 0; alu_out = 0;
        #1 cmp_en = 1;
        tick(3);
        reset = 0;
        tick(2);

        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        chk("lit_wr_en", rf_wr_en, 1);
        chk("lit_wr_addr", rf_addr, 4'h5);
        chk("lit_wr_data", rf_wr_data, 8'h3C);
        tick(1);
        chk("lit_wr_single", rf_wr_en, 0);

        send_byte(8'hBB); send_byte(8'h07);
        chk("lit_rd_en", rf_rd_en, 1);
        chk("lit_rd_addr", rf_addr, 4'h7);
        tick(2);
        rf_rd_data_vld = 1; rf_rd_data = 8'h5A;
        tick(1);
        rf_rd_data_vld = 0; rf_rd_data = 8'h00;
        chk("lit_tx_rf_send", tx_rf_send, 1);
        chk("lit_tx_rf_data", tx_rf_send_data, 8'h5A);
        tick(1);

        send_byte(8'hCC);
        send_byte(8'h03);
        chk("lit_opa", {rf_wr_en, rf_addr, rf_wr_data}, {1'b1, 4'h0, 8'h03});
        send_byte(8'h04);
        chk("lit_opb", {rf_wr_en, rf_addr, rf_wr_data}, {1'b1, 4'h1, 8'h04});
        send_byte(8'h00);
        chk("lit_alu_wait", {alu_en, clk_gate_en, alu_fun}, {1'b1, 1'b1, 4'h0});
        tick(1);
        alu_out_vld = 1; alu_out = 16'h0007;
        tick(1);
        alu_out_vld = 0; alu_out = 0;
        chk("lit_tx_alu", {tx_alu_send, alu_en, tx_alu_send_data}, {1'b1, 1'b0, 16'h0007});

        send_byte(8'hDD); send_byte(8'h02);
        chk("lit_dd_fun", alu_fun, 4'h2);
        tick(WAIT_MAX - 1);
        chk("lit_dd_still_wait", alu_en, 1);
        tick(1);
        chk("lit_dd_timeout", {alu_en, clk_gate_en, tx_alu_send}, 3'b000);

        send_byte(8'h11); send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
        chk("lit_drop_wr", {rf_wr_en, rf_addr, rf_wr_data}, {1'b1, 4'h1, 8'hFF});

        send_byte(8'hAA); send_byte(8'h02);
        reset = 1;
        #1 chk("lit_async_rst", {rf_addr, rf_wr_data}, 12'h000);
        tick(1);
        reset = 0;
        tick(1);
        send_byte(8'h77);
        tick(2);
        chk("lit_after_rst", {rf_wr_en, rf_addr}, 5'd0);
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h44);
        chk("lit_post_rst_wr", {rf_wr_en, rf_addr, rf_wr_data}, {1'b1, 4'h3, 8'h44});

        for (int i = 0; i < 4000; i++) begin
            rx_d_vld       = ($urandom_range(2) == 0);
            rx_p_data      = ($urandom_range(1) == 0) ? opc[$urandom_range(3)] : 8'($urandom);
            rf_rd_data_vld = ($urandom_range(7) == 0);
            rf_rd_data     = 8'($urandom);
            alu_out_vld    = ($urandom_range(9) == 0);
            alu_out        = 16'($urandom);
            reset          = ($urandom_range(299) == 0);
            @(posedge clk); #2;
        end
        reset = 0; rx_d_vld = 0; rf_rd_data_vld = 0; alu_out_vld = 0;
        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
